// File: rtl/fpnew_cast_out_buffer.sv
// ---------------------------------------------------------------------------
// fpnew_cast_out_buffer
//
// This is the output stage that sits after the int-to-float cast unit. It
// accepts one result per valid/ready handshake and stores up to Depth entries
// in order. On the way out it NaN-boxes each result to Flen bits. It also keeps
// sticky fflags, the OR of the status of every result that has retired, until
// software clears them.
//
// Ports
//   clk_i, rst_ni          clock; synchronous active-low reset
//   result_i, status_i     incoming cast result and its {NV,DZ,OF,UF,NX} flags
//   extension_bit_i        1: box with ones, 0: pad with zeros
//   tag_i                  opaque tag that travels with the result
//   in_valid_i/in_ready_o  upstream handshake (ready only when not full)
//   flush_i                drop every stored entry
//   result_o, status_o,    head-of-FIFO entry, with result_o boxed to Flen
//   tag_o
//   out_valid_o/out_ready_i writeback handshake
//   fflags_o, fflags_clr_i sticky flags and their clear
//   busy_o                 at least one entry is stored
// ---------------------------------------------------------------------------
module fpnew_cast_out_buffer #(
    parameter int unsigned DstWidth = 32,
    parameter int unsigned Flen     = 64,
    parameter int unsigned Depth    = 2,
    parameter int unsigned TagWidth = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [DstWidth-1:0] result_i,
    input  logic [4:0]          status_i,
    input  logic                extension_bit_i,
    input  logic [TagWidth-1:0] tag_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                flush_i,
    output logic [Flen-1:0]     result_o,
    output logic [4:0]          status_o,
    output logic [TagWidth-1:0] tag_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [4:0]          fflags_o,
    input  logic                fflags_clr_i,
    output logic                busy_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [DstWidth-1:0] res_mem [Depth];
    logic [4:0]          st_mem  [Depth];
    logic                ext_mem [Depth];
    logic [TagWidth-1:0] tag_mem [Depth];

    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic [4:0]      fflags_q;
    logic            push, pop;
    logic [4:0]      fflags_d;

    // Depth need not be a power of two, so the wrap is an explicit compare.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) return '0;
        return p + PtrW'(1);
    endfunction

    // Ready depends only on the stored count. A full buffer does not take a
    // new entry even when the head leaves in the same cycle, which keeps
    // out_ready_i out of the in_ready_o timing path.
    assign in_ready_o  = (count_q != CntW'(Depth));
    assign out_valid_o = (count_q != '0);
    assign busy_o      = out_valid_o;

    assign push = in_valid_i & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & out_ready_i & ~flush_i;

    always_comb begin
        fflags_d = fflags_q;
        if (fflags_clr_i) fflags_d = 5'b0;
        if (pop)          fflags_d = fflags_d | st_mem[rd_ptr_q];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            fflags_q <= 5'b0;
        end else begin
            fflags_q <= fflags_d;
            if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CntW'(1);
                    2'b01:   count_q <= count_q - CntW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Entry storage is not reset. The head outputs are only meaningful while
    // out_valid_o is high.
    always_ff @(posedge clk_i) begin
        if (push) begin
            res_mem[wr_ptr_q] <= result_i;
            st_mem[wr_ptr_q]  <= status_i;
            ext_mem[wr_ptr_q] <= extension_bit_i;
            tag_mem[wr_ptr_q] <= tag_i;
        end
    end

    assign status_o = st_mem[rd_ptr_q];
    assign tag_o    = tag_mem[rd_ptr_q];
    assign fflags_o = fflags_q;

    generate
        if (Flen > DstWidth) begin : g_box
            assign result_o = {{(Flen - DstWidth){ext_mem[rd_ptr_q]}}, res_mem[rd_ptr_q]};
        end else begin : g_nobox
            assign result_o = res_mem[rd_ptr_q];
        end
    endgenerate

endmodule

// File: tb/tb_fpnew_cast_out_buffer.sv
module tb_fpnew_cast_out_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] result_i;
    logic [4:0]  status_i;
    logic        ext_i;
    logic [0:0]  tag_i;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [63:0] result_o;
    logic [4:0]  status_o;
    logic [0:0]  tag_o;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  fflags;
    logic        fflags_clr;
    logic        busy;

    always #5 clk = ~clk;

    fpnew_cast_out_buffer #(
        .DstWidth(32), .Flen(64), .Depth(2), .TagWidth(1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .result_i(result_i), .status_i(status_i), .extension_bit_i(ext_i),
        .tag_i(tag_i), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .flush_i(flush), .result_o(result_o), .status_o(status_o),
        .tag_o(tag_o), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .fflags_o(fflags), .fflags_clr_i(fflags_clr), .busy_o(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue of boxed entries and a flag word.
    typedef struct {
        logic [63:0] res;
        logic [4:0]  st;
        logic        tag;
    } entry_t;

    localparam int DEPTH = 2;
    entry_t      mq[$];
    logic [4:0]  m_ff;

    typedef struct {
        logic        iv;
        logic [31:0] res;
        logic [4:0]  st;
        logic        ext;
        logic        tag;
        logic        ordy;
        logic        fl;
        logic        clr;
        logic        e_valid;
        logic        e_ready;
        logic [63:0] e_res;
        logic [4:0]  e_st;
        logic        e_tag;
        logic [4:0]  e_ff;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] box(input logic [31:0] r, input logic e);
        return e ? (64'hFFFF_FFFF_0000_0000 | {32'h0, r}) : {32'h0, r};
    endfunction

    task automatic check_model(input string pfx);
        chk({pfx, "_valid"}, {63'h0, out_valid}, {63'h0, mq.size() != 0});
        chk({pfx, "_ready"}, {63'h0, in_ready}, {63'h0, mq.size() != DEPTH});
        chk({pfx, "_busy"}, {63'h0, busy}, {63'h0, mq.size() != 0});
        chk({pfx, "_fflags"}, {59'h0, fflags}, {59'h0, m_ff});
        if (mq.size() != 0) begin
            chk({pfx, "_result"}, result_o, mq[0].res);
            chk({pfx, "_status"}, {59'h0, status_o}, {59'h0, mq[0].st});
            chk({pfx, "_tag"}, {63'h0, tag_o}, {63'h0, mq[0].tag});
        end
    endtask

    task automatic do_cycle(input logic iv, input logic [31:0] res, input logic [4:0] st,
                            input logic ext, input logic tg, input logic ordy,
                            input logic fl, input logic clr, input string pfx);
        bit     m_push, m_pop;
        entry_t e;
        logic [4:0] nff;
        in_valid   = iv;
        result_i   = res;
        status_i   = st;
        ext_i      = ext;
        tag_i      = tg;
        out_ready  = ordy;
        flush      = fl;
        fflags_clr = clr;
        m_push = iv && (mq.size() != DEPTH) && !fl;
        m_pop  = (mq.size() != 0) && ordy && !fl;
        nff = clr ? 5'b0 : m_ff;
        if (m_pop) begin
            e = mq.pop_front();
            nff = nff | e.st;
        end
        m_ff = nff;
        if (fl) mq.delete();
        if (m_push) begin
            e.res = box(res, ext);
            e.st  = st;
            e.tag = tg;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
        check_model(pfx);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 0; result_i = 0; status_i = 0; ext_i = 0; tag_i = 0;
        out_ready = 0; flush = 0; fflags_clr = 0;
        mq.delete();
        m_ff = 5'b0;

        //        iv res           st      ext tag rdy fl clr | valid rdy result                 st       tag ff
        vecs[0]  = '{1, 32'h3F80_0000, 5'b00000, 1, 1, 0, 0, 0, 1, 1, 64'hFFFF_FFFF_3F80_0000, 5'b00000, 1, 5'b00000};
        vecs[1]  = '{1, 32'h4000_0000, 5'b00001, 0, 0, 0, 0, 0, 1, 0, 64'hFFFF_FFFF_3F80_0000, 5'b00000, 1, 5'b00000};
        vecs[2]  = '{1, 32'h4040_0000, 5'b10000, 1, 1, 0, 0, 0, 1, 0, 64'hFFFF_FFFF_3F80_0000, 5'b00000, 1, 5'b00000};
        vecs[3]  = '{1, 32'h4040_0000, 5'b10000, 1, 1, 1, 0, 0, 1, 1, 64'h0000_0000_4000_0000, 5'b00001, 0, 5'b00000};
        vecs[4]  = '{1, 32'h4040_0000, 5'b10000, 1, 1, 1, 0, 0, 1, 1, 64'hFFFF_FFFF_4040_0000, 5'b10000, 1, 5'b00001};
        vecs[5]  = '{0, 32'h0,         5'b00000, 0, 0, 1, 0, 0, 0, 1, 64'h0,                   5'b00000, 0, 5'b10001};
        vecs[6]  = '{0, 32'h0,         5'b00000, 0, 0, 0, 0, 1, 0, 1, 64'h0,                   5'b00000, 0, 5'b00000};
        vecs[7]  = '{1, 32'h3F80_0000, 5'b10000, 0, 0, 0, 0, 0, 1, 1, 64'h0000_0000_3F80_0000, 5'b10000, 0, 5'b00000};
        vecs[8]  = '{1, 32'hBF80_0000, 5'b00001, 1, 1, 1, 0, 0, 1, 1, 64'hFFFF_FFFF_BF80_0000, 5'b00001, 1, 5'b10000};
        vecs[9]  = '{0, 32'h0,         5'b00000, 0, 0, 1, 0, 1, 0, 1, 64'h0,                   5'b00000, 0, 5'b00001};
        vecs[10] = '{1, 32'hC000_0000, 5'b00100, 0, 0, 0, 0, 0, 1, 1, 64'h0000_0000_C000_0000, 5'b00100, 0, 5'b00001};
        vecs[11] = '{1, 32'h1234_5678, 5'b00010, 1, 1, 0, 0, 0, 1, 0, 64'h0000_0000_C000_0000, 5'b00100, 0, 5'b00001};
        vecs[12] = '{1, 32'h1111_1111, 5'b01000, 1, 1, 1, 1, 0, 0, 1, 64'h0,                   5'b00000, 0, 5'b00001};
        vecs[13] = '{0, 32'h0,         5'b00000, 0, 0, 0, 0, 0, 0, 1, 64'h0,                   5'b00000, 0, 5'b00001};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {63'h0, out_valid}, 64'h0);
        chk("reset_busy", {63'h0, busy}, 64'h0);
        chk("reset_ready", {63'h0, in_ready}, 64'h1);
        chk("reset_fflags", {59'h0, fflags}, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            string p;
            p = $sformatf("tbl%0d", i);
            do_cycle(vecs[i].iv, vecs[i].res, vecs[i].st, vecs[i].ext, vecs[i].tag,
                     vecs[i].ordy, vecs[i].fl, vecs[i].clr, p);
            chk({p, "_hvalid"}, {63'h0, out_valid}, {63'h0, vecs[i].e_valid});
            chk({p, "_hready"}, {63'h0, in_ready}, {63'h0, vecs[i].e_ready});
            chk({p, "_hff"}, {59'h0, fflags}, {59'h0, vecs[i].e_ff});
            if (vecs[i].e_valid) begin
                chk({p, "_hres"}, result_o, vecs[i].e_res);
                chk({p, "_hst"}, {59'h0, status_o}, {59'h0, vecs[i].e_st});
                chk({p, "_htag"}, {63'h0, tag_o}, {63'h0, vecs[i].e_tag});
            end
        end

        // Random soak against the queue model: order, wrap-around, flags.
        for (int i = 0; i < 3000; i++) begin
            do_cycle($urandom_range(0, 3) != 0, $urandom(), 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
                     $urandom_range(0, 20) == 0, "soak");
        end

        // Reset in the middle of operation drops entries and clears flags.
        do_cycle(1, 32'hAAAA_5555, 5'b11111, 1, 1, 0, 0, 0, "prerst0");
        do_cycle(1, 32'h5555_AAAA, 5'b00011, 0, 0, 1, 0, 0, "prerst1");
        in_valid = 1'b1;
        out_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        mq.delete();
        m_ff = 5'b0;
        rst_n = 1'b1;
        check_model("midrst");
        do_cycle(1, 32'h3F80_0000, 5'b00001, 1, 0, 0, 0, 0, "postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
